// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
// Covers funct3 sizes, FSM states, byte-enable generation and load extension.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Store lanes: size picks the lane count, the byte offset shifts them into place.
    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << off;
            F3_H:    be = 4'b0011 << off;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  off,
                                                 input logic [31:0] word);
        logic [31:0] s;
        logic [31:0] r;
        s = word >> {off, 3'b000};
        case (f3)
            F3_B:    r = {{24{s[7]}}, s[7:0]};
            F3_H:    r = {{16{s[15]}}, s[15:0]};
            F3_W:    r = s;
            F3_BU:   r = {24'h0, s[7:0]};
            F3_HU:   r = {16'h0, s[15:0]};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // A request is illegal when the op is ambiguous, the size is unknown for the op, or misaligned.
    function automatic logic req_error(input logic       rd,
                                       input logic       wr,
                                       input logic [2:0] f3,
                                       input logic [1:0] off);
        logic bad;
        bad = (rd == wr);
        if (rd) begin
            bad = bad | !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end else begin
            bad = bad | !(f3 inside {F3_B, F3_H, F3_W});
        end
        if (f3 == F3_H || f3 == F3_HU) begin
            bad = bad | off[0];
        end
        if (f3 == F3_W) begin
            bad = bad | (off != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// DEPTH x 32 word storage: byte-enable synchronous write, combinational read.
module mem_word_array #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    // NOTE: storage has no reset; clearing a RAM costs a write port per word and contents are undefined by design.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one load/store at a time, fixed access latency,
// RV32I sizing with sign/zero extension, and a registered response with error flag.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rdata,
    output logic        rsp_err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [2:0] LAT_INIT = 3'(LATENCY - 1);

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [2:0]    f3_q, f3_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          enter_resp;
    logic          cur_rd, cur_wr, cur_err;
    logic [2:0]    cur_f3;
    logic [AW+1:0] cur_addr;
    logic [31:0]   cur_wdata;
    logic [1:0]    cur_off;
    logic [31:0]   mem_word;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic          unused_addr_hi;

    // With LATENCY==1 the access completes on the accept edge, so the live inputs
    // stand in for the not-yet-latched request while idle.
    always_comb begin
        if (state_q == IDLE) begin
            cur_rd    = mem_read;
            cur_wr    = mem_write;
            cur_f3    = funct3;
            cur_addr  = addr[AW+1:0];
            cur_wdata = wdata;
        end else begin
            cur_rd    = rd_q;
            cur_wr    = wr_q;
            cur_f3    = f3_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    assign cur_off        = cur_addr[1:0];
    assign cur_err        = req_error(cur_rd, cur_wr, cur_f3, cur_off);
    assign mem_be         = byte_enable(cur_f3, cur_off);
    assign mem_we         = enter_resp & cur_wr & ~cur_err;
    assign unused_addr_hi = ^addr[31:AW+2];

    mem_word_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .be_i    (mem_be),
        .idx_i   (cur_addr[AW+1:2]),
        .wdata_i (cur_wdata << {cur_off, 3'b000}),
        .rdata_o (mem_word)
    );

    // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    rd_d    = mem_read;
                    wr_d    = mem_write;
                    f3_d    = funct3;
                    addr_d  = addr[AW+1:0];
                    wdata_d = wdata;
                    cnt_d   = LAT_INIT;
                    if (LATENCY == 1) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            state_d = RESP;
            err_d   = cur_err;
            rdata_d = (cur_err || !cur_rd) ? 32'h0 : load_extract(cur_f3, cur_off, mem_word);
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rdata     = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed, table-driven bench for data_mem_responder (DEPTH=512, LATENCY=2).
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rdata;
    logic        rsp_err;

    int total = 0;
    int bad = 0;

    data_mem_responder #(.DEPTH(512), .LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rdata     (rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.name = n; v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present a request at the falling edge; returns #1 after the accept edge.
    task automatic issue(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        check({name, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic wait_rsp(input string name);
        int cyc;
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({name, "_latency"}, 32'(cyc), 32'(LAT));
    endtask

    task automatic finish_rsp(input string name);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({name, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        check({name, "_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        issue(v.name, v.rd, v.wr, v.f3, v.a, v.wd);
        wait_rsp(v.name);
        check({v.name, "_rdata"}, rdata, v.exp_rdata);
        check({v.name, "_err"}, 32'(rsp_err), 32'(v.exp_err));
        finish_rsp(v.name);
    endtask

    initial begin
        vecs.push_back(mk("sw_10",       0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h00000000, 0));
        vecs.push_back(mk("lw_10",       1, 0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0));
        vecs.push_back(mk("sb_13",       0, 1, 3'b000, 32'h13,  32'h00000080, 32'h00000000, 0));
        vecs.push_back(mk("lb_13",       1, 0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80, 0));
        vecs.push_back(mk("lbu_13",      1, 0, 3'b100, 32'h13,  32'h0,        32'h00000080, 0));
        vecs.push_back(mk("lw_10_b",     1, 0, 3'b010, 32'h10,  32'h0,        32'h80ADBEEF, 0));
        vecs.push_back(mk("lh_11_mis",   1, 0, 3'b001, 32'h11,  32'h0,        32'h00000000, 1));
        vecs.push_back(mk("sw_12_mis",   0, 1, 3'b010, 32'h12,  32'h11111111, 32'h00000000, 1));
        vecs.push_back(mk("lw_10_c",     1, 0, 3'b010, 32'h10,  32'h0,        32'h80ADBEEF, 0));
        vecs.push_back(mk("lh_12",       1, 0, 3'b001, 32'h12,  32'h0,        32'hFFFF80AD, 0));
        vecs.push_back(mk("lhu_12",      1, 0, 3'b101, 32'h12,  32'h0,        32'h000080AD, 0));
        vecs.push_back(mk("lb_10",       1, 0, 3'b000, 32'h10,  32'h0,        32'hFFFFFFEF, 0));
        vecs.push_back(mk("sh_10",       0, 1, 3'b001, 32'h10,  32'hAAAA1234, 32'h00000000, 0));
        vecs.push_back(mk("lw_10_d",     1, 0, 3'b010, 32'h10,  32'h0,        32'h80AD1234, 0));
        vecs.push_back(mk("lw_11_mis",   1, 0, 3'b010, 32'h11,  32'h0,        32'h00000000, 1));
        vecs.push_back(mk("no_op",       0, 0, 3'b010, 32'h10,  32'h0,        32'h00000000, 1));
        vecs.push_back(mk("ld_f3_011",   1, 0, 3'b011, 32'h10,  32'h0,        32'h00000000, 1));
        vecs.push_back(mk("st_f3_100",   0, 1, 3'b100, 32'h10,  32'hFFFFFFFF, 32'h00000000, 1));
        vecs.push_back(mk("lw_10_e",     1, 0, 3'b010, 32'h10,  32'h0,        32'h80AD1234, 0));
        vecs.push_back(mk("sw_800",      0, 1, 3'b010, 32'h800, 32'h12345678, 32'h00000000, 0));
        vecs.push_back(mk("lw_0_wrap",   1, 0, 3'b010, 32'h0,   32'h0,        32'h12345678, 0));
        vecs.push_back(mk("lhu_2",       1, 0, 3'b101, 32'h2,   32'h0,        32'h00001234, 0));
        vecs.push_back(mk("sw_20",       0, 1, 3'b010, 32'h20,  32'hCAFEF00D, 32'h00000000, 0));

        #2;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rdata",     rdata,          32'h0);
        check("reset_rsp_err",   32'(rsp_err),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i]);
        end

        // Conflicting op held under back-pressure: response must stay frozen.
        issue("rdwr", 1, 1, 3'b010, 32'h10, 32'h55555555);
        wait_rsp("rdwr");
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_err",   32'(rsp_err),   32'd1);
            check("stall_rdata", rdata,          32'h0);
            check("stall_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        finish_rsp("rdwr");
        run_vec(mk("lw_10_f", 1, 0, 3'b010, 32'h10, 32'h0, 32'h80AD1234, 0));

        // Reset during WAIT of a store: response dropped, store discarded.
        issue("sw_20_rst", 0, 1, 3'b010, 32'h20, 32'h0BADF00D);
        check("rst_in_wait", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk("lw_20_after_rst", 1, 0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
